// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue. The master side is the
// pipeline (fetch pushes, decode pops); the slave side is the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   F_PC;
  logic [31:0]   F_instruction;
  logic          push;
  logic          pop;
  logic          flush;
  logic [31:0]   D_PC;
  logic [31:0]   D_instruction;
  logic          D_valid;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output F_PC, F_instruction, push, pop, flush,
    input  D_PC, D_instruction, D_valid, full, count, overflow
  );

  modport slave (
    input  F_PC, F_instruction, push, pop, flush,
    output D_PC, D_instruction, D_valid, full, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: a small circular buffer of {PC, instruction} pairs sitting
// between the fetch and decode stages. The head entry is presented
// combinationally; an empty queue presents a NOP at PC 0x3000 with
// D_valid low. Dropped pushes on a full queue latch a sticky overflow flag.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] IDLE_PC  = 32'h0000_3000;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          eff_pop;
  logic          acc_push;
  logic          drop_push;
  logic [63:0]   head;

  // Decide which of this cycle's requests actually take effect; flush wins.
  always_comb begin
    eff_pop   = bus.pop & ~bus.flush & (cnt != '0);
    acc_push  = bus.push & ~bus.flush & ((cnt != FULL_CNT) | eff_pop);
    drop_push = bus.push & ~bus.flush & ~acc_push;
  end

  // Entry storage is written verbatim and never reset; only pointers matter.
  always_ff @(posedge clk) begin
    if (!reset && acc_push) begin
      mem[wp] <= {bus.F_PC, bus.F_instruction};
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (bus.flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (eff_pop) begin
        rp <= rp + AW'(1);
      end
      if (acc_push) begin
        wp <= wp + AW'(1);
      end
      case ({acc_push, eff_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop_push) begin
        ovf <= 1'b1;
      end
    end
  end

  // Head presentation and status flags, all derived from stored state only.
  always_comb begin
    head              = mem[rp];
    bus.D_valid       = (cnt != '0);
    bus.D_PC          = bus.D_valid ? head[63:32] : IDLE_PC;
    bus.D_instruction = bus.D_valid ? head[31:0]  : NOP_WORD;
    bus.full          = (cnt == FULL_CNT);
    bus.count         = cnt;
    bus.overflow      = ovf;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model is
// compared against the DUT every cycle, and directed scenarios pin the
// model with literal expectations.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hDEAD_0013;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   modelReady;

  logic [63:0] mq[$];
  logic        mOvf;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model at the edge.
  task automatic applyStimulus(input logic rst, input logic psh, input logic pp,
                               input logic fl, input logic [31:0] pc,
                               input logic [31:0] instr);
    bit hadRoom;
    bit doPop;
    reset             = rst;
    bus.push          = psh;
    bus.pop           = pp;
    bus.flush         = fl;
    bus.F_PC          = pc;
    bus.F_instruction = instr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mOvf = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      hadRoom = (mq.size() < DEPTH);
      doPop   = pp && (mq.size() > 0);
      if (doPop) void'(mq.pop_front());
      if (psh) begin
        if (hadRoom || doPop) mq.push_back({pc, instr});
        else mOvf = 1'b1;
      end
    end
    modelReady = 1'b1;
    #1;
  endtask

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    if (modelReady) begin
      logic [63:0] expHead;
      expHead = (mq.size() > 0) ? mq[0] : {32'h0000_3000, NOP};
      checkOutput("model.D_valid", 32'(bus.D_valid), 32'(mq.size() > 0));
      checkOutput("model.D_PC", bus.D_PC, expHead[63:32]);
      checkOutput("model.D_instruction", bus.D_instruction, expHead[31:0]);
      checkOutput("model.count", 32'(bus.count), 32'(mq.size()));
      checkOutput("model.full", 32'(bus.full), 32'(mq.size() == DEPTH));
      checkOutput("model.overflow", 32'(bus.overflow), 32'(mOvf));
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    modelReady = 1'b0;
    mOvf       = 1'b0;
    reset      = 1'b1;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.flush  = 1'b0;
    bus.F_PC   = '0;
    bus.F_instruction = '0;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 32'h1111_1111, 32'h2222_2222);
    checkOutput("rst.D_valid", 32'(bus.D_valid), 0);
    checkOutput("rst.D_PC", bus.D_PC, 32'h0000_3000);
    checkOutput("rst.D_instruction", bus.D_instruction, NOP);
    checkOutput("rst.full", 32'(bus.full), 0);
    checkOutput("rst.count", 32'(bus.count), 0);
    checkOutput("rst.overflow", 32'(bus.overflow), 0);

    // Single push becomes visible one cycle later.
    applyStimulus(0, 1, 0, 0, 32'h0000_3000, 32'h2401_0001);
    checkOutput("push1.D_valid", 32'(bus.D_valid), 1);
    checkOutput("push1.D_PC", bus.D_PC, 32'h0000_3000);
    checkOutput("push1.D_instruction", bus.D_instruction, 32'h2401_0001);
    checkOutput("push1.count", 32'(bus.count), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Fill to four, then a fifth push is dropped and flags overflow.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, 0, 32'h0000_3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    checkOutput("fill.count", 32'(bus.count), 4);
    checkOutput("fill.full", 32'(bus.full), 1);
    applyStimulus(0, 1, 0, 0, 32'h0000_3010, 32'h1000_0004);
    checkOutput("drop.overflow", 32'(bus.overflow), 1);
    checkOutput("drop.D_PC", bus.D_PC, 32'h0000_3000);
    checkOutput("drop.count", 32'(bus.count), 4);

    // Push and pop together on a full queue.
    applyStimulus(0, 1, 1, 0, 32'h0000_3010, 32'h1000_0004);
    checkOutput("fullpp.count", 32'(bus.count), 4);
    checkOutput("fullpp.D_PC", bus.D_PC, 32'h0000_3004);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("fullpp.late_PC", bus.D_PC, 32'h0000_3010);
    checkOutput("fullpp.late_instr", bus.D_instruction, 32'h1000_0004);

    // Reset clears the sticky flag and queued entries.
    applyStimulus(0, 1, 0, 0, 32'h0000_3014, 32'h1000_0005);
    checkOutput("pre_rst.count", 32'(bus.count), 2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("midrst.count", 32'(bus.count), 0);
    checkOutput("midrst.overflow", 32'(bus.overflow), 0);

    // Pop on empty queue is harmless.
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("emptypop.count", 32'(bus.count), 0);
    checkOutput("emptypop.overflow", 32'(bus.overflow), 0);

    // Continuous streaming across pointer wrap.
    applyStimulus(0, 1, 0, 0, 32'h0000_3000, 32'h3000_0000);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 1, 0, 32'h0000_3000 + 32'(4 * i), 32'h3000_0000 + 32'(i));
      checkOutput("stream.D_PC", bus.D_PC, 32'h0000_3000 + 32'(4 * i));
    end
    checkOutput("stream.overflow", 32'(bus.overflow), 0);
    checkOutput("stream.count", 32'(bus.count), 1);

    // Flush beats concurrent push and pop and leaves overflow alone.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 0, 0, 32'h0000_3000 + 32'(4 * i), 32'h4000_0000 + 32'(i));
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("preflush.count", 32'(bus.count), 3);
    applyStimulus(0, 1, 1, 1, 32'h0000_3099, 32'h4000_0099);
    checkOutput("flush.count", 32'(bus.count), 0);
    checkOutput("flush.D_valid", 32'(bus.D_valid), 0);
    checkOutput("flush.D_PC", bus.D_PC, 32'h0000_3000);
    checkOutput("flush.overflow", 32'(bus.overflow), 1);
    applyStimulus(0, 1, 0, 0, 32'h0000_4000, 32'h4000_4000);
    checkOutput("postflush.D_PC", bus.D_PC, 32'h0000_4000);

    // Mixed traffic pattern checked by the model alone.
    for (int i = 0; i < 80; i++)
      applyStimulus(0, (i % 3) != 0, (i % 4) == 0 || (i % 5) == 0, (i % 17) == 16,
                    32'h0000_5000 + 32'(4 * i), 32'hA000_0000 ^ 32'(i));
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word presented while the queue is empty.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 F_PC  input  32  address of the fetched instruction.
REQ-006 F_instruction  input  32  instruction word read at F_PC.
REQ-007 push  input  1  fetch side offers {F_PC, F_instruction} this cycle.
REQ-008 pop  input  1  decode side consumes the head entry this cycle (decode not stalled).
REQ-009 flush  input  1  discard all queued entries (redirect / clear).
REQ-010 D_PC  output  32  PC of the head entry.
REQ-011 D_instruction  output  32  instruction of the head entry.
REQ-012 D_valid  output  1  head entry holds a real instruction.
REQ-013 full  output  1  combinational, count==DEPTH; drives the fetch-stage stop_sel.
REQ-014 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-015 overflow  output  1  sticky error flag.

Function
REQ-016 Storage: DEPTH-entry circular buffer of 64-bit {PC, instruction}; read pointer rp, write pointer wp, each log2(DEPTH) bits, SHALL wrap modulo DEPTH.
REQ-017 D_PC/D_instruction/D_valid SHALL be combinational from the head entry: when count>0 -> entry[rp], D_valid=1; when count==0 -> D_PC=32'h0000_3000, D_instruction=NOP_WORD, D_valid=0.
REQ-018 Latency: an entry pushed at edge N SHALL be visible on D_* after edge N (no same-cycle bypass from F_* to D_*).
REQ-019 Accepted push = push & ~flush & (count<DEPTH | effective pop); writes entry[wp], wp+1.
REQ-020 Effective pop = pop & ~flush & count>0; rp+1; pop with count==0 SHALL be ignored without error.
REQ-021 Count update: +1 on push-only, -1 on pop-only, unchanged on simultaneous accepted push and effective pop, including when count==DEPTH.
REQ-022 push while count==DEPTH and no effective pop SHALL be dropped, leave state unchanged, and set overflow=1.
REQ-023 flush SHALL have priority over push and pop in the same cycle: next count=0, rp=wp=0, concurrent push discarded, overflow unchanged.
REQ-024 overflow SHALL remain 1 until reset; nothing else clears it.
REQ-025 Entry contents SHALL be stored verbatim; no arithmetic on PC inside the block.
REQ-026 full SHALL depend only on count, never combinationally on push/pop/flush.

Reset
REQ-027 reset=1 at an edge SHALL set count=0, rp=wp=0, overflow=0, overriding push, pop and flush.
REQ-028 After reset, D_valid=0, D_PC=32'h0000_3000, D_instruction=NOP_WORD, full=0.
REQ-029 reset mid-operation SHALL discard all queued entries; stored data need not be cleared.

Verification
REQ-030 Reset then push {0x3000,0x24010001} one cycle -> next cycle D_valid=1, D_PC=0x3000, D_instruction=0x24010001, count=1.
REQ-031 Push 4 entries PC 0x3000..0x300C with pop=0 -> count=4, full=1; 5th push -> dropped, overflow=1, D_PC still 0x3000.
REQ-032 Full queue, push 0x3010 with pop same cycle -> count stays 4, D_PC=0x3004, entry 0x3010 appears after three further pops.
REQ-033 Push/pop continuously for 10 cycles (pointer wrap) -> D_PC sequence 0x3000,0x3004,... in order, no loss, overflow=0.
REQ-034 count=3, assert flush with push and pop -> next cycle count=0, D_valid=0, D_PC=0x3000, overflow unchanged.
REQ-035 Pop with empty queue -> count stays 0, overflow=0; reset with count=2, overflow=1 -> count=0, overflow=0.
